// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills the instruction memory from a framed byte stream
// (16-bit LE length, little-endian payload words, optional XOR checksum) and
// holds the core stalled until a complete image has been written.
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing checksum byte).
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_buf_q, word_buf_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic [CNT_W-1:0]  word_count_d;
  logic              imem_we_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic              rx_ready_d;
  logic              core_stall_d;
  logic              done_d;
  logic              err_d;
  logic              accept;
  logic              last_word;
  logic [15:0]       len_full;

  // Next-state and next-output logic; registered outputs follow the next state
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif
    word_count_d = word_count;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    accept       = rx_valid && rx_ready;
    last_word    = (word_count + CNT_W'(1)) == len_q;
    len_full     = {rx_data, len_lo_q};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN0;
          word_count_d = '0;
          byte_idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d       = '0;
`endif
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          if (len_full > DEPTH_LEN) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_TAIL;
          end else begin
            len_d   = CNT_W'(len_full);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count[ADDR_W-1:0];
            imem_wdata_d = {rx_data, word_buf_q};
            word_count_d = word_count + CNT_W'(1);
            if (last_word) state_d = S_TAIL;
          end else begin
            word_buf_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    rx_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
`ifdef IMEM_LOADER_CSUM_EN
                   (state_d == S_CSUM) ||
`endif
                   (state_d == S_DATA);
    core_stall_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d       = state_d == S_DONE;
    err_d        = state_d == S_ERR;
  end

  // State and output registers; reset aborts any session in the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      rx_ready   <= 1'b0;
      core_stall <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
      word_count <= word_count_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      rx_ready   <= rx_ready_d;
      core_stall <= core_stall_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: cycle table for a 3-word frame plus
// hand sequences for length error, empty frame, full-depth load with gaps,
// mid-session reset and (with IMEM_LOADER_CSUM_EN) a bad checksum.
module tb_imem_boot_loader;

  localparam logic [31:0] W0 = 32'h00108113;
  localparam logic [31:0] W1 = 32'h003101B3;
  localparam logic [31:0] W2 = 32'h00302123;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_stall;
  logic        done;
  logic        err;
  logic [9:0]  word_count;

  imem_boot_loader #(.ADDR_W(9), .DEPTH(512)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_stall (core_stall),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  dt;
    logic        rdy;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic        stall;
    logic        dn;
    logic        er;
    logic [9:0]  wc;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side instruction memory fed by the write strobes
  logic [31:0] mem_model [512];
  int          we_count = 0;
  int          seq_err  = 0;
  logic [8:0]  last_addr = '0;

  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (we_count != 0 && imem_addr != 9'(last_addr + 9'd1) && imem_addr != 9'd0)
        seq_err++;
      mem_model[imem_addr] = imem_wdata;
      last_addr = imem_addr;
      we_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] outs();
    return {rx_ready, imem_we, imem_addr, imem_wdata, core_stall, done, err, word_count};
  endfunction

  task automatic vadd(input logic st, input logic vl, input logic [7:0] dt,
                      input logic rdy, input logic we, input logic [8:0] addr,
                      input logic [31:0] wd, input logic stall, input logic dn,
                      input logic er, input logic [9:0] wc);
    vec_t v;
    v.st = st; v.vl = vl; v.dt = dt; v.rdy = rdy; v.we = we; v.addr = addr;
    v.wd = wd; v.stall = stall; v.dn = dn; v.er = er; v.wc = wc;
    vecs.push_back(v);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_rdy_stall", {62'd0, rx_ready, core_stall}, 64'd3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: rx_ready %b expected 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  function automatic logic [31:0] wgen(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  initial begin
    int          base;
    int          bad;
    logic [7:0]  cs;
    logic [31:0] w;

    // Cycle table: 3-word frame, inputs per cycle and outputs seen that cycle
    vadd(1, 0, 8'h00, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    vadd(0, 1, 8'h03, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'h13, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'h81, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 0, 8'h55, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'h10, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0, 0);
    vadd(0, 1, 8'hB3, 1, 1, 0, W0,    1, 0, 0, 1);
    vadd(1, 1, 8'h01, 1, 0, 0, W0,    1, 0, 0, 1);
    vadd(0, 1, 8'h31, 1, 0, 0, W0,    1, 0, 0, 1);
    vadd(0, 1, 8'h00, 1, 0, 0, W0,    1, 0, 0, 1);
    vadd(0, 1, 8'h23, 1, 1, 1, W1,    1, 0, 0, 2);
    vadd(0, 1, 8'h21, 1, 0, 1, W1,    1, 0, 0, 2);
    vadd(0, 0, 8'hFF, 1, 0, 1, W1,    1, 0, 0, 2);
    vadd(0, 1, 8'h30, 1, 0, 1, W1,    1, 0, 0, 2);
    vadd(0, 1, 8'h00, 1, 0, 1, W1,    1, 0, 0, 2);
`ifdef IMEM_LOADER_CSUM_EN
    vadd(0, 1, 8'h33, 1, 1, 2, W2,    1, 0, 0, 3);
    vadd(0, 0, 8'h00, 0, 0, 2, W2,    0, 1, 0, 3);
`else
    vadd(0, 0, 8'h00, 0, 1, 2, W2,    0, 1, 0, 3);
`endif
    vadd(0, 0, 8'h00, 0, 0, 2, W2,    0, 1, 0, 3);
    vadd(0, 0, 8'h00, 0, 0, 2, W2,    0, 1, 0, 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_values", {8'd0, outs()}, 64'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), {8'd0, outs()},
          {8'd0, vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd,
           vecs[i].stall, vecs[i].dn, vecs[i].er, vecs[i].wc});
      start    = vecs[i].st;
      rx_valid = vecs[i].vl;
      rx_data  = vecs[i].dt;
    end
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("tbl_writes", 64'(we_count), 64'd3);
    chk("tbl_mem", {mem_model[0], mem_model[1]}, {W0, W1});
    chk("tbl_mem2", 64'(mem_model[2]), 64'(W2));

    // Length 513: err the cycle after the LEN1 byte, no writes
    base = we_count;
    do_start();
    chk("restart_clears", {53'd0, done, err, word_count}, 64'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("len_err_flags", {60'd0, err, done, core_stall, rx_ready}, 64'b1010);
    repeat (3) @(posedge clk);
    chk("len_err_nowrite", 64'(we_count - base), 64'd0);

    // Empty frame
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
    chk("empty_in_csum", {62'd0, rx_ready, done}, 64'b10);
    send_byte(8'h00);
`endif
    chk("empty_done", {60'd0, done, err, core_stall, rx_ready}, 64'b1000);

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum: writes happen, err raised, core stays stalled
    base = we_count;
    do_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(W0);
    send_word(W1);
    send_word(W2);
    send_byte(8'h32);
    chk("badcs_flags", {60'd0, err, done, core_stall, rx_ready}, 64'b1010);
    repeat (2) @(posedge clk);
    chk("badcs_writes", 64'(we_count - base), 64'd3);
    chk("badcs_wc", 64'(word_count), 64'd3);
`endif

    // Full-depth frame with random rx_valid gaps
    base = we_count;
    bad  = 0;
    cs   = 8'h00;
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 512; i++) begin
      w = wgen(i);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        send_byte(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(cs);
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 512; i++) if (mem_model[i] !== wgen(i)) bad++;
    chk("full_mem", 64'(bad), 64'd0);
    chk("full_writes", 64'(we_count - base), 64'd512);
    chk("full_order", 64'(seq_err), 64'd0);
    chk("full_last_addr", 64'(last_addr), 64'd511);
    chk("full_status", {50'd0, done, err, core_stall, rx_ready, word_count}, {50'd0, 4'b1000, 10'd512});

    // Reset after 6 payload bytes, then a 1-word load
    do_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h44332211);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_values", {8'd0, outs()}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_kept", 64'(mem_model[0]), 64'h44332211);
    base = we_count;
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDEADBEEF);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h22);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reload_mem", {mem_model[0], 23'd0, last_addr}, {32'hDEADBEEF, 32'd0});
    chk("reload_writes", 64'(we_count - base), 64'd1);
    chk("reload_status", {50'd0, done, err, core_stall, rx_ready, word_count}, {50'd0, 4'b1000, 10'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
